// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding and operand forward-select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    // Hazard controller states; MEM_WAIT remembers which of the others it interrupted.
    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        REDIRECT   = 2'b10,
        MEM_WAIT   = 2'b11
    } hz_state_t;

    // ALU operand source select driven to the E-stage muxes.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-select for one E-stage source operand: picks M result, W result or register file.
// Latency: purely combinational.
// Backpressure: none; the caller gates the result during reset.
module fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    output logic [1:0]            sel
);

    // M holds the younger result, so it wins over W; x0 is hardwired zero and never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch redirect flush, memory-wait hold, operand forwarding.
// Latency: stall/flush/forward outputs are combinational from inputs and the registered FSM state.
// Backpressure: mem_ready=0 holds all four stages and defers pending redirect flushes. Optional HAZARD_PERF_EN adds stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  load_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    input  logic                  pc_src_e,
    input  logic                  mem_ready,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_cycles,
`endif
    output logic [1:0]            fwd_a_e,
    output logic [1:0]            fwd_b_e
);

    hz_state_t state, state_nxt;
    hz_state_t ret_state, ret_nxt;   // state interrupted by a memory wait
    logic      pend, pend_nxt;       // redirect seen while E was held
    hz_state_t eff_state;
    logic      eff_pc;
    logic      load_use;
    logic [1:0] sel_a, sel_b;

    assign load_use = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // On leaving MEM_WAIT, act exactly as the interrupted state would, with any held redirect replayed.
    assign eff_state = (state == MEM_WAIT) ? ret_state : state;
    assign eff_pc    = pc_src_e || ((state == MEM_WAIT) && pend);

    // State, resume state and pending-redirect registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            ret_state <= RUN;
            pend      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            pend      <= pend_nxt;
        end
    end

    // Next-state and stall/flush decode; redirect beats load-use, memory wait beats everything.
    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        state_nxt = state;
        ret_nxt   = ret_state;
        pend_nxt  = pend;
        if (!mem_ready) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            stall_e   = 1'b1;
            stall_m   = 1'b1;
            state_nxt = MEM_WAIT;
            if (state == MEM_WAIT) begin
                pend_nxt = pend || pc_src_e;
            end else begin
                ret_nxt  = state;
                pend_nxt = pc_src_e;
            end
        end else begin
            ret_nxt  = RUN;
            pend_nxt = 1'b0;
            case (eff_state)
                REDIRECT: begin
                    // Fetch's registered next PC means one more wrong-path instruction reaches D.
                    flush_d   = 1'b1;
                    state_nxt = RUN;
                end
                default: begin
                    if (eff_pc) begin
                        flush_d   = 1'b1;
                        flush_e   = 1'b1;
                        state_nxt = REDIRECT;
                    end else if ((eff_state == RUN) && load_use) begin
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        flush_e   = 1'b1;
                        state_nxt = LOAD_STALL;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            endcase
        end
        // Reset fills D and E with bubbles and releases every hold.
        if (reset) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            stall_e = 1'b0;
            stall_m = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs          (rs1_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .sel         (sel_a)
    );

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs          (rs2_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .sel         (sel_b)
    );

    assign fwd_a_e = reset ? FWD_RF : sel_a;
    assign fwd_b_e = reset ? FWD_RF : sel_b;

`ifdef HAZARD_PERF_EN
    // Saturating counters of fetch-stall cycles and D-flush cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall_f && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_d && (flush_cycles != '1)) begin
                flush_cycles <= flush_cycles + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, redirect, memory wait, forwarding and reset.
// Latency: checks combinational outputs mid-cycle, state after each rising edge.
// Backpressure: exercises mem_ready=0 holds with and without a pending redirect.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, reg_write_m, reg_write_w, pc_src_e, mem_ready;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [5:0] ctl;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_e        (rd_e),
        .load_e      (load_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .pc_src_e    (pc_src_e),
        .mem_ready   (mem_ready),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .stall_e     (stall_e),
        .stall_m     (stall_m),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .fwd_a_e     (fwd_a_e),
        .fwd_b_e     (fwd_b_e)
    );

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        load_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0; mem_ready = 1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        // Forward candidates present during reset must still read as register file.
        rs1_e = 7; rd_m = 7; reg_write_m = 1;
        #3;
        chk("reset_ctl", {2'b0, ctl}, 8'b00_000011);
        chk("reset_fwd_a", {6'b0, fwd_a_e}, {6'b0, FWD_RF});
        chk("reset_state", {6'b0, dut.state}, {6'b0, RUN});
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_fwd_a", {6'b0, fwd_a_e}, {6'b0, FWD_M});
        idle();
        tick();

        // Load-use on rs1: one stall cycle, then one quiet cycle, then RUN.
        load_e = 1; rd_e = 5; rs1_d = 5;
        #2 chk("lu_c0", {2'b0, ctl}, 8'b00_110001);
        tick();
        #2 chk("lu_c1", {2'b0, ctl}, 8'b00_000000);
        chk("lu_c1_state", {6'b0, dut.state}, {6'b0, LOAD_STALL});
        tick();
        idle();
        #2 chk("lu_c2_state", {6'b0, dut.state}, {6'b0, RUN});
        chk("lu_c2", {2'b0, ctl}, 8'b00_000000);
        tick();

        // Destination x0 never stalls.
        load_e = 1; rd_e = 0; rs1_d = 0; rs2_d = 0;
        #2 chk("lu_x0", {2'b0, ctl}, 8'b00_000000);
        // Load-use on rs2.
        rd_e = 4; rs2_d = 4;
        #2 chk("lu_rs2", {2'b0, ctl}, 8'b00_110001);
        tick();
        idle();
        tick();

        // Branch: flush_d two cycles, flush_e the first only.
        pc_src_e = 1;
        #2 chk("br_c0", {2'b0, ctl}, 8'b00_000011);
        tick();
        pc_src_e = 0;
        #2 chk("br_c1", {2'b0, ctl}, 8'b00_000010);
        tick();
        #2 chk("br_c2", {2'b0, ctl}, 8'b00_000000);
        tick();

        // Branch and load-use together: branch wins, no stall.
        pc_src_e = 1; load_e = 1; rd_e = 3; rs2_d = 3;
        #2 chk("brlu_c0", {2'b0, ctl}, 8'b00_000011);
        tick();
        idle();
        #2 chk("brlu_c1", {2'b0, ctl}, 8'b00_000010);
        tick();
        #2 chk("brlu_c2", {2'b0, ctl}, 8'b00_000000);
        tick();

        // Memory wait of three cycles in REDIRECT, then the remaining flush_d.
        pc_src_e = 1;
        #2 chk("mw_c0", {2'b0, ctl}, 8'b00_000011);
        tick();
        pc_src_e = 0; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #2 chk($sformatf("mw_hold%0d", i), {2'b0, ctl}, 8'b00_111100);
            tick();
        end
        mem_ready = 1;
        #2 chk("mw_resume", {2'b0, ctl}, 8'b00_000010);
        tick();
        #2 chk("mw_done", {2'b0, ctl}, 8'b00_000000);
        tick();

        // Redirect arriving under a memory wait is deferred and replayed.
        mem_ready = 0; pc_src_e = 1;
        #2 chk("pend_hold0", {2'b0, ctl}, 8'b00_111100);
        tick();
        pc_src_e = 0;
        #2 chk("pend_hold1", {2'b0, ctl}, 8'b00_111100);
        tick();
        mem_ready = 1;
        #2 chk("pend_c0", {2'b0, ctl}, 8'b00_000011);
        tick();
        #2 chk("pend_c1", {2'b0, ctl}, 8'b00_000010);
        tick();
        #2 chk("pend_c2", {2'b0, ctl}, 8'b00_000000);
        tick();

        // Forwarding selects.
        rd_m = 7; rd_w = 7; rs1_e = 7; reg_write_m = 1; reg_write_w = 1;
        #2 chk("fwd_m_wins", {6'b0, fwd_a_e}, 8'b10);
        rs1_e = 0;
        #2 chk("fwd_x0", {6'b0, fwd_a_e}, 8'b00);
        rs1_e = 7; reg_write_m = 0;
        #2 chk("fwd_w_only", {6'b0, fwd_a_e}, 8'b01);
        reg_write_m = 1; rd_m = 3; rs2_e = 7;
        #2 chk("fwd_b_w", {6'b0, fwd_b_e}, 8'b01);
        rs2_e = 3;
        #2 chk("fwd_b_m", {6'b0, fwd_b_e}, 8'b10);
        rs2_e = 9;
        #2 chk("fwd_b_rf", {6'b0, fwd_b_e}, 8'b00);
        idle();
        tick();

        // Reset pulse during LOAD_STALL.
        load_e = 1; rd_e = 6; rs1_d = 6;
        tick();
        #2 chk("rst_ls_state", {6'b0, dut.state}, {6'b0, LOAD_STALL});
        rs1_e = 7; rd_m = 7; reg_write_m = 1;
        reset = 1'b1;
        #1 chk("rst_ls_ctl", {2'b0, ctl}, 8'b00_000011);
        chk("rst_ls_fwd", {6'b0, fwd_a_e}, 8'b00);
        chk("rst_ls_state_now", {6'b0, dut.state}, {6'b0, RUN});
        tick();
        #2 chk("rst_ls_ctl_held", {2'b0, ctl}, 8'b00_000011);
        load_e = 0;
        reset = 1'b0;
        #1 chk("rst_rel_ctl", {2'b0, ctl}, 8'b00_000000);
        chk("rst_rel_fwd", {6'b0, fwd_a_e}, 8'b10);
        tick();
        #2 chk("rst_rel_state", {6'b0, dut.state}, {6'b0, RUN});
        chk("rst_rel_ctl2", {2'b0, ctl}, 8'b00_000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be: REG_ADDR_W, 5, register-index width; CNT_W, 32, perf counter width.
REQ-002 Ports SHALL be: clk  in  1  pipeline clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 rs1_d, rs2_d  in  REG_ADDR_W each  source registers of the instruction in D.
REQ-005 rs1_e, rs2_e, rd_e  in  REG_ADDR_W each  sources and destination of the instruction in E.
REQ-006 load_e  in  1  instruction in E is a load.
REQ-007 rd_m, rd_w  in  REG_ADDR_W each  destinations in M and W.
REQ-008 reg_write_m, reg_write_w  in  1 each  M and W write the register file.
REQ-009 pc_src_e  in  1  taken branch or jump resolved in E, the same signal that drives the fetch stage's pc_src.
REQ-010 mem_ready  in  1  data memory ready; low means M must hold.
REQ-011 stall_f, stall_d, stall_e, stall_m  out  1 each  hold the stage register (stall_f drives the fetch stage's stall_f).
REQ-012 flush_d, flush_e  out  1 each  load a bubble into the stage register.
REQ-013 fwd_a_e, fwd_b_e  out  2 each  operand select: 00 register file, 01 W result, 10 M result.

Function
REQ-014 The FSM SHALL have states RUN, LOAD_STALL, REDIRECT and MEM_WAIT, held in one registered state variable.
REQ-015 Load-use SHALL be: load_e=1, rd_e!=0, and rd_e equals rs1_d or rs2_d.
REQ-016 In RUN with a load-use hazard, outputs SHALL be stall_f=1, stall_d=1, flush_e=1 in that cycle, then the FSM goes to LOAD_STALL.
REQ-017 LOAD_STALL SHALL drive no stall or flush and SHALL return to RUN next cycle, giving exactly one bubble.
REQ-018 On pc_src_e=1 (RUN or LOAD_STALL), outputs SHALL be flush_d=1 and flush_e=1 in that cycle, then the FSM goes to REDIRECT.
REQ-019 REDIRECT SHALL assert flush_d=1 for one more cycle, because fetch holds a registered next PC and the redirected instruction reaches D two edges after pc_src_e; the FSM then goes to RUN.
REQ-020 pc_src_e SHALL take priority over load-use in the same cycle, with no stall.
REQ-021 mem_ready=0 in any state SHALL assert all four stalls with no flushes and enter MEM_WAIT.
REQ-022 MEM_WAIT SHALL record its entry state and any pending redirect flush, and SHALL resume them on the first mem_ready=1 cycle.
REQ-023 While stall_e=1, the flushes for a pending redirect SHALL be deferred, not dropped.
REQ-024 Forwarding SHALL be combinational: 10 if reg_write_m and rd_m!=0 and rd_m==rsX_e, else 01 if reg_write_w and rd_w!=0 and rd_w==rsX_e, else 00; M wins over W.
REQ-025 Register index 0 SHALL never cause a stall or a forward.

Reset
REQ-026 Reset SHALL set state to RUN and clear the pending flags and counters.
REQ-027 While reset=1, outputs SHALL be stalls 0, flush_d=1, flush_e=1, fwd 00.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL abandon that sequence immediately.

Configuration
REQ-029 With HAZARD_PERF_EN defined, outputs stall_cycles and flush_cycles (CNT_W each) SHALL exist.
REQ-030 stall_cycles SHALL count cycles with stall_f=1, flush_cycles SHALL count cycles with flush_d=1, and both SHALL saturate at all-ones.
REQ-031 Without HAZARD_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 The state encoding typedef and the forward-select constants (FWD_RF, FWD_W, FWD_M) SHALL live in the shared pipeline package.
REQ-033 The forwarding compare SHALL be one sub-module, fwd_sel, instantiated once per operand.

Verification
REQ-034 Load-use: load_e=1, rd_e=5, rs1_d=5 -> cycle 0 stall_f/stall_d/flush_e=1; cycle 1 all 0; state RUN at cycle 2.
REQ-035 Branch: pc_src_e=1 for one cycle -> flush_d=1 for two consecutive cycles, flush_e=1 for the first only.
REQ-036 Simultaneous branch and load-use: pc_src_e=1, load_e=1, rd_e=rs2_d=3 -> no stalls; two-cycle flush as in REQ-035.
REQ-037 mem_ready=0 for 3 cycles during REDIRECT -> all stalls 1 for 3 cycles; then the remaining flush_d=1 for one cycle.
REQ-038 Forwarding: rd_m=rd_w=rs1_e=7, both writes 1 -> fwd_a_e=10; with rs1_e=0 -> fwd_a_e=00.
REQ-039 Reset pulse during LOAD_STALL -> outputs match REQ-027 while reset=1, and a clean RUN state after release.
